mem_ctrl: RTL

Memory controller for the RISC-V core. It answers the fetch stage's instruction-read requests and the MEM stage's data load/store requests. Both are served over the single byte-wide synchronous RAM port, with 32-bit little-endian words assembled from four byte accesses. The controller holds the `busy` line high toward each requester until its word is ready, which is what drives the fetch stage's stall request.

---
 rtl/mem_ctrl_pkg.sv | 32 +++
 rtl/mem_byte_seq.sv | 100 ++++++++++
 rtl/mem_ctrl.sv | 139 +++++++++++++
 3 files changed

// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the byte-serial memory controller:
// width codes, controller states, common constants and a length helper.
package mem_ctrl_pkg;

  localparam logic        True_v    = 1'b1;
  localparam logic        False_v   = 1'b0;
  localparam logic        RstEnable = 1'b1;
  localparam logic [31:0] ZeroWord  = 32'h0000_0000;

  localparam logic [1:0] MEM_BYTE = 2'b00;
  localparam logic [1:0] MEM_HALF = 2'b01;
  localparam logic [1:0] MEM_WORD = 2'b10;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    INST_RD = 2'd1,
    DATA_RD = 2'd2,
    DATA_WR = 2'd3
  } state_e;

  // Access length in bytes; code 11 is treated as a word.
  function automatic logic [2:0] width_len(input logic [1:0] w);
    logic [2:0] n;
    case (w)
      MEM_BYTE: n = 3'd1;
      MEM_HALF: n = 3'd2;
      default:  n = 3'd4;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/mem_byte_seq.sv
// Byte-serial RAM sequencer: counter, address stepping, byte assembly/extraction.
// Ports: rdy_i/start_i/wr_i/addr_i/len_i/wdata_i in, done_o/word_o result, mem_* RAM side.
module mem_byte_seq
  import mem_ctrl_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy_i,
  input  logic              start_i,
  input  logic              wr_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [2:0]        len_i,
  input  logic [31:0]       wdata_i,
  input  logic [7:0]        mem_din_i,
  output logic              done_o,
  output logic [31:0]       word_o,
  output logic [ADDR_W-1:0] mem_a_o,
  output logic [7:0]        mem_dout_o,
  output logic              mem_wr_o
);

  localparam logic [ADDR_W-1:0] AOne = {{(ADDR_W-1){1'b0}}, 1'b1};

  logic              act_q;
  logic              wr_q;
  logic [2:0]        cnt_q;
  logic [2:0]        len_q;
  logic [ADDR_W-1:0] a_q;
  logic [7:0]        dout_q;
  logic [31:0]       wd_q;
  logic [31:0]       buf_q;
  logic [31:0]       word_d;
  logic              last_d;

  // On reads, cnt counts edges since acceptance; the byte on mem_din
  // belongs to index cnt-1 because the RAM answers one cycle late.
  always_comb begin
    word_d = buf_q;
    case (cnt_q)
      3'd1:    word_d[7:0]   = mem_din_i;
      3'd2:    word_d[15:8]  = mem_din_i;
      3'd3:    word_d[23:16] = mem_din_i;
      3'd4:    word_d[31:24] = mem_din_i;
      default: ;
    endcase
  end

  assign last_d = wr_q ? (cnt_q == len_q - 3'd1) : (cnt_q == len_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst == RstEnable) begin
      act_q  <= False_v;
      wr_q   <= False_v;
      cnt_q  <= 3'd0;
      len_q  <= 3'd0;
      a_q    <= '0;
      dout_q <= 8'h00;
      wd_q   <= ZeroWord;
      buf_q  <= ZeroWord;
    end else if (rdy_i) begin
      if (start_i) begin
        act_q  <= True_v;
        wr_q   <= wr_i;
        cnt_q  <= 3'd0;
        len_q  <= len_i;
        a_q    <= addr_i;
        dout_q <= wdata_i[7:0];
        wd_q   <= wdata_i >> 8;
        buf_q  <= ZeroWord;
      end else if (act_q) begin
        if (last_d) begin
          act_q <= False_v;
          cnt_q <= 3'd0;
        end else begin
          cnt_q <= cnt_q + 3'd1;
        end
        if (wr_q) begin
          if (!last_d) begin
            a_q    <= a_q + AOne;
            dout_q <= wd_q[7:0];
            wd_q   <= wd_q >> 8;
          end
        end else begin
          buf_q <= word_d;
          if (cnt_q + 3'd1 < len_q) a_q <= a_q + AOne;
        end
      end
    end
  end

  assign done_o     = act_q & rdy_i & last_d;
  assign word_o     = word_d;
  assign mem_a_o    = a_q;
  assign mem_dout_o = dout_q;
  // Gated by rdy so a frozen cycle writes nothing; the byte replays later.
  assign mem_wr_o   = act_q & wr_q & rdy_i;

endmodule

// File: rtl/mem_ctrl.sv
// Memory controller: arbitrates fetch and MEM-stage requests onto one byte RAM port.
// Ports: inst_* fetch side, data_* load/store side, mem_* RAM side, rdy global enable.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              inst_re,
  input  logic [ADDR_W-1:0] inst_addr,
  output logic [31:0]       inst,
  output logic              inst_busy,
  input  logic              data_re,
  input  logic              data_we,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [1:0]        data_width,
  input  logic [31:0]       data_wdata,
  output logic [31:0]       data_rdata,
  output logic              data_busy,
  output logic [ADDR_W-1:0] mem_a,
  output logic [7:0]        mem_dout,
  output logic              mem_wr,
  input  logic [7:0]        mem_din
);

  state_e            state_q;
  logic [31:0]       inst_q;
  logic [31:0]       rdata_q;
  logic              ibusy_q;
  logic              dbusy_q;

  logic              start_d;
  logic              wr_d;
  logic              data_d;
  logic [ADDR_W-1:0] addr_d;
  logic [2:0]        len_d;
  logic              seq_done;
  logic [31:0]       seq_word;

  // Data port wins over fetch; store wins over load.
  always_comb begin
    start_d = False_v;
    wr_d    = False_v;
    data_d  = False_v;
    addr_d  = inst_addr;
    len_d   = 3'd4;
    if (state_q == IDLE) begin
      priority case (1'b1)
        data_we: begin
          start_d = True_v;
          wr_d    = True_v;
          data_d  = True_v;
          addr_d  = data_addr;
          len_d   = width_len(data_width);
        end
        data_re: begin
          start_d = True_v;
          data_d  = True_v;
          addr_d  = data_addr;
          len_d   = width_len(data_width);
        end
        inst_re: start_d = True_v;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst == RstEnable) begin
      state_q <= IDLE;
      inst_q  <= ZeroWord;
      rdata_q <= ZeroWord;
      ibusy_q <= False_v;
      dbusy_q <= False_v;
    end else if (rdy) begin
      case (state_q)
        IDLE: begin
          if (start_d) begin
            if (!data_d) begin
              state_q <= INST_RD;
              ibusy_q <= True_v;
            end else begin
              state_q <= wr_d ? DATA_WR : DATA_RD;
              dbusy_q <= True_v;
            end
          end
        end
        INST_RD: begin
          if (seq_done) begin
            inst_q  <= seq_word;
            ibusy_q <= False_v;
            state_q <= IDLE;
          end
        end
        DATA_RD: begin
          if (seq_done) begin
            rdata_q <= seq_word;
            dbusy_q <= False_v;
            state_q <= IDLE;
          end
        end
        DATA_WR: begin
          if (seq_done) begin
            dbusy_q <= False_v;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  mem_byte_seq #(
    .ADDR_W(ADDR_W)
  ) u_seq (
    .clk       (clk),
    .rst       (rst),
    .rdy_i     (rdy),
    .start_i   (start_d),
    .wr_i      (wr_d),
    .addr_i    (addr_d),
    .len_i     (len_d),
    .wdata_i   (data_wdata),
    .mem_din_i (mem_din),
    .done_o    (seq_done),
    .word_o    (seq_word),
    .mem_a_o   (mem_a),
    .mem_dout_o(mem_dout),
    .mem_wr_o  (mem_wr)
  );

  assign inst       = inst_q;
  assign data_rdata = rdata_q;
  assign inst_busy  = ibusy_q;
  assign data_busy  = dbusy_q;

endmodule
